fetch_queue_stage: RTL and testbench
====================================

// Module: fetch_queue_stage
// PURPOSE
//  Decoupled instruction-fetch stage for the pipelined MIPS core; successor to the single-cycle IF stage.
//  Drives a request/response instruction-memory port with in-order, variable-latency responses.
//  Buffers fetched words in a DEPTH-entry FIFO ahead of decode, using credit-based flow control.
//  Handles jump/branch redirects: flushes the queue and discards responses still in flight.
// PARAMETERS
//  WIDTH     32  data/address width (bits)
//  DEPTH     4   fetch-queue entries; power of 2, >=2; also the maximum requests in flight
//  RESET_PC  0   fetch address after reset
//  PC_INC    4   sequential address increment
// PORTS
//  clk             in   1      single clock; all state updates on rising edge
//  rst             in   1      synchronous, active-high reset
//  jump_decode     in   1      redirect to pc_jump
//  pcsrc_decode    in   1      redirect to pc_branch
//  pc_branch       in   WIDTH  branch target
//  pc_jump         in   WIDTH  jump target
//  imem_req_valid  out  1      fetch request valid
//  imem_req_addr   out  WIDTH  fetch address
//  imem_req_ready  in   1      memory accepts request this cycle
//  imem_rsp_valid  in   1      response valid; responses arrive in request order
//  imem_rsp_data   in   WIDTH  instruction word
//  instr_valid     out  1      queue head valid
//  instr_fetch     out  WIDTH  head instruction
//  pc_fetch        out  WIDTH  head instruction address + PC_INC
//  decode_ready    in   1      decode consumes head when instr_valid && decode_ready (low = stall)
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - fetch_pc <= RESET_PC; queue count, outstanding count and discard count <= 0.
//   - imem_req_valid=0, instr_valid=0, instr_fetch=0, pc_fetch=0 during the reset cycle.
//   - rst mid-operation: queue empties; responses still in flight after rst are ignored (discard count is cleared, not loaded).
//  Issue:
//   - imem_req_valid = !rst && !redirect && (count + outstanding < DEPTH).
//   - imem_req_addr = fetch_pc.
//   - On accept (valid && ready): fetch_pc += PC_INC (mod 2^WIDTH, wrap allowed); outstanding += 1.
//  Redirect:
//   - redirect = jump_decode | pcsrc_decode.
//   - jump_decode has priority: target = jump_decode ? pc_jump : pc_branch.
//   - Redirect cycle issues no request; fetch_pc <= target.
//   - Queue is flushed (count <= 0). A dequeue in the same cycle has no other effect.
//   - Discard count <= outstanding - (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is dropped.
//   - First request to target is issued the next cycle.
//  Response:
//   - On imem_rsp_valid: outstanding -= 1.
//   - If discard count > 0: drop the word and decrement discard count.
//   - Otherwise: enqueue {data, addr+PC_INC}, where addr is tracked per request in a DEPTH-entry address FIFO.
//   - The credit rule guarantees no overflow.
//  Dequeue:
//   - instr_valid = count != 0; head data is registered FIFO output.
//   - Enqueue and dequeue in the same cycle leave count unchanged; the FIFO pointers wrap mod DEPTH.
//  Latency:
//   - With a zero-wait memory (ready=1, rsp one cycle after accept): request at cycle N, instr_valid at N+2.
//   - Steady-state throughput is 1 instruction/cycle when DEPTH>=2 and decode_ready=1.
//  Counters:
//   - outstanding and discard counters are $clog2(DEPTH+1) bits wide.
//   - Invariant: count + outstanding <= DEPTH. A response arriving with outstanding==0 is a protocol error and the word is ignored.
// TESTING
//  - Reset: rst 2 cycles, RESET_PC=0 -> imem_req_valid=0 during reset; first req addr 0x0 the cycle after rst drops.
//  - Streaming, zero-wait memory, decode_ready=1 -> instr_valid from cycle 2 onward.
//    pc_fetch sequence 0x4, 0x8, 0xC, ...; one instruction per cycle.
//  - decode_ready=0, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0.
//    decode_ready=1 again -> head is the word for addr 0x0 and issue resumes.
//  - Redirect with 2 responses in flight, pc_branch=0x100 -> both stale responses dropped; queue empty.
//    Next accepted req addr 0x100; first instr_valid has pc_fetch 0x104.
//  - jump_decode=1 and pcsrc_decode=1 together, pc_jump=0x200, pc_branch=0x300 -> fetch resumes at 0x200.
//  - rst mid-stream with 3 in flight -> outputs cleared; fetch restarts at RESET_PC.
//    Stale responses returning after rst never reach decode.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage
//
// Decoupled instruction-fetch stage. Issues in-order requests to a
// variable-latency instruction memory and buffers the returned words in a
// DEPTH-entry queue ahead of decode. Requests are credit-limited so that
// queued words plus requests in flight never exceed DEPTH, which means the
// queue cannot overflow. A jump/branch redirect flushes the queue and marks
// every request still in flight as stale, so its response is dropped.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   jump_decode     redirect to pc_jump (wins over pcsrc_decode)
//   pcsrc_decode    redirect to pc_branch
//   pc_branch       branch target
//   pc_jump         jump target
//   imem_req_valid  fetch request valid
//   imem_req_addr   fetch address
//   imem_req_ready  memory accepts the request this cycle
//   imem_rsp_valid  response valid (responses return in request order)
//   imem_rsp_data   instruction word
//   instr_valid     queue head valid
//   instr_fetch     head instruction word
//   pc_fetch        head instruction address + PC_INC
//   decode_ready    decode consumes the head when instr_valid is high
// ---------------------------------------------------------------------------
module fetch_queue_stage #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_decode,
  input  logic             pcsrc_decode,
  input  logic [WIDTH-1:0] pc_branch,
  input  logic [WIDTH-1:0] pc_jump,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr_fetch,
  output logic [WIDTH-1:0] pc_fetch,
  input  logic             decode_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  // Architectural state
  logic [WIDTH-1:0] r_fetch_pc;
  logic [CNT_W-1:0] r_count;        // words held in the fetch queue
  logic [CNT_W-1:0] r_outstanding;  // requests accepted, response not yet seen
  logic [CNT_W-1:0] r_discard;      // in-flight responses known to be stale

  // Fetch queue (instruction word + its pc_fetch value)
  logic [PTR_W-1:0] r_q_wr;
  logic [PTR_W-1:0] r_q_rd;
  logic [WIDTH-1:0] r_q_instr [DEPTH];
  logic [WIDTH-1:0] r_q_pc    [DEPTH];

  // Address FIFO: one entry per request in flight, popped by every response
  // (kept or dropped) so it stays aligned with the in-order response stream.
  logic [PTR_W-1:0] r_a_wr;
  logic [PTR_W-1:0] r_a_rd;
  logic [WIDTH-1:0] r_a_addr [DEPTH];

  // Per-cycle decisions
  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic             w_credit_ok;
  logic             w_req_valid;
  logic             w_accept;
  logic             w_rsp;
  logic             w_enq;
  logic             w_deq;
  logic             w_head_valid;
  logic [WIDTH-1:0] w_rsp_pc;

  assign w_redirect  = jump_decode | pcsrc_decode;
  assign w_target    = jump_decode ? pc_jump : pc_branch;

  // Credit: a request is only issued if its word is guaranteed a queue slot.
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_L;
  assign w_req_valid = !rst && !w_redirect && w_credit_ok;
  assign w_accept    = w_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error (e.g. a request
  // issued before reset returning afterwards) and is ignored entirely.
  assign w_rsp       = !rst && imem_rsp_valid && (r_outstanding != '0);

  // A response in a redirect cycle belongs to the old stream: drop it.
  assign w_enq       = w_rsp && !w_redirect && (r_discard == '0);

  assign w_head_valid = !rst && (r_count != '0);
  assign w_deq        = w_head_valid && decode_ready && !w_redirect;
  assign w_rsp_pc     = r_a_addr[r_a_rd] + PC_INC;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = w_head_valid;
  // Storage is unreset, so the head is forced to zero whenever it is invalid.
  assign instr_fetch    = w_head_valid ? r_q_instr[r_q_rd] : '0;
  assign pc_fetch       = w_head_valid ? r_q_pc[r_q_rd]    : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge values of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_q_wr        <= '0;
      r_q_rd        <= '0;
      r_a_wr        <= '0;
      r_a_rd        <= '0;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + PC_INC;
        r_a_wr     <= r_a_wr + PTR_W'(1);
      end
      if (w_rsp) begin
        r_a_rd <= r_a_rd + PTR_W'(1);
      end
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);

      if (w_redirect) begin
        // Later assignment overrides the sequential increment above; no
        // request is accepted in a redirect cycle anyway.
        r_fetch_pc <= w_target;
        r_count    <= '0;
        r_q_wr     <= '0;
        r_q_rd     <= '0;
        // Everything still in flight after this edge is stale.
        r_discard  <= r_outstanding - CNT_W'(w_rsp);
      end else begin
        if (w_enq) begin
          r_q_wr <= r_q_wr + PTR_W'(1);
        end
        if (w_deq) begin
          r_q_rd <= r_q_rd + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        if (w_rsp && (r_discard != '0)) begin
          r_discard <= r_discard - CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the storage arrays carry no reset; validity is tracked entirely by
  // the pointers and counters above, and w_accept/w_enq are low during rst.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_addr[r_a_wr] <= r_fetch_pc;
    end
    if (w_enq) begin
      r_q_instr[r_q_wr] <= imem_rsp_data;
      r_q_pc[r_q_wr]    <= w_rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_stage
//
// Directed bench for fetch_queue_stage (WIDTH=32, DEPTH=4, RESET_PC=0,
// PC_INC=4). A small in-order memory model holds accepted addresses and,
// when enabled, answers the oldest one the cycle after it is accepted with
// the word {16'hC0DE, addr[15:0]}. All expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_decode;
  logic        pcsrc_decode;
  logic [31:0] pc_branch;
  logic [31:0] pc_jump;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr_fetch;
  logic [31:0] pc_fetch;
  logic        decode_ready;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  logic [31:0] pend[$];
  logic        mem_auto;

  fetch_queue_stage #(
    .WIDTH   (32),
    .DEPTH   (4),
    .RESET_PC(32'h0),
    .PC_INC  (32'h4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_decode   (jump_decode),
    .pcsrc_decode  (pcsrc_decode),
    .pc_branch     (pc_branch),
    .pc_jump       (pc_jump),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_fetch   (instr_fetch),
    .pc_fetch      (pc_fetch),
    .decode_ready  (decode_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present the oldest pending response, if the memory is answering.
  task automatic mem_drive();
    if (mem_auto && pend.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {16'hC0DE, pend[0][15:0]};
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  // One clock: note handshakes before the edge, update memory after it.
  task automatic tick();
    logic        acc;
    logic        fired;
    logic [31:0] a;
    acc   = imem_req_valid && imem_req_ready;
    fired = imem_rsp_valid;
    a     = imem_req_addr;
    @(posedge clk);
    #1;
    if (acc) n_acc++;
    if (fired && pend.size() != 0) pend.delete(0);
    if (acc) pend.push_back(a);
    mem_drive();
    #1;
  endtask

  // Two-cycle reset of DUT and memory model.
  task automatic reset_dut(input logic auto_rsp);
    rst      = 1'b1;
    mem_auto = 1'b0;
    mem_drive();
    tick();
    tick();
    pend.delete();
    rst      = 1'b0;
    mem_auto = auto_rsp;
    mem_drive();
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    jump_decode    = 1'b0;
    pcsrc_decode   = 1'b0;
    pc_branch      = 32'h0;
    pc_jump        = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    decode_ready   = 1'b1;
    mem_auto       = 1'b1;
    #1;

    // ---- Reset ----
    check("rst_req_valid",   imem_req_valid, 0);
    check("rst_instr_valid", instr_valid,    0);
    check("rst_instr_fetch", instr_fetch,    0);
    check("rst_pc_fetch",    pc_fetch,       0);
    tick();
    check("rst_req_valid_2", imem_req_valid, 0);
    tick();
    rst = 1'b0;
    #1;
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr",  imem_req_addr,  32'h0);
    check("c0_instr_valid",  instr_valid,    0);

    // ---- Streaming, zero-wait memory ----
    tick();
    check("c1_instr_valid", instr_valid,   0);
    check("c1_req_addr",    imem_req_addr, 32'h4);
    tick();
    for (int k = 2; k < 8; k++) begin
      check("stream_instr_valid", instr_valid,   1);
      check("stream_pc_fetch",    pc_fetch,      32'(4 * (k - 1)));
      check("stream_instr_fetch", instr_fetch,   32'hC0DE_0000 | 32'(4 * (k - 2)));
      check("stream_req_addr",    imem_req_addr, 32'(4 * k));
      tick();
    end

    // ---- Decode stall fills the queue ----
    decode_ready = 1'b0;
    reset_dut(1'b1);
    n_acc = 0;
    repeat (8) tick();
    check("stall_accepts",    32'(n_acc),     4);
    check("stall_req_valid",  imem_req_valid, 0);
    check("stall_instr_valid", instr_valid,   1);
    check("stall_head_pc",    pc_fetch,       32'h4);
    check("stall_head_instr", instr_fetch,    32'hC0DE_0000);
    decode_ready = 1'b1;
    #1;
    tick();
    check("resume_req_valid", imem_req_valid, 1);
    check("resume_req_addr",  imem_req_addr,  32'h10);
    check("resume_head_pc",   pc_fetch,       32'h8);

    // ---- Branch redirect with two responses in flight ----
    reset_dut(1'b0);
    tick();
    tick();
    check("br_pre_req_addr", imem_req_addr, 32'h8);
    pcsrc_decode = 1'b1;
    pc_branch    = 32'h100;
    #1;
    check("br_req_blocked", imem_req_valid, 0);
    tick();
    pcsrc_decode = 1'b0;
    mem_auto     = 1'b1;
    mem_drive();
    #1;
    check("br_req_valid",     imem_req_valid, 1);
    check("br_req_addr",      imem_req_addr,  32'h100);
    check("br_instr_valid_0", instr_valid,    0);
    tick();
    check("br_stale0_dropped", instr_valid, 0);
    tick();
    check("br_stale1_dropped", instr_valid,   0);
    check("br_req_addr_2",     imem_req_addr, 32'h108);
    tick();
    check("br_first_valid", instr_valid, 1);
    check("br_first_pc",    pc_fetch,    32'h104);
    check("br_first_instr", instr_fetch, 32'hC0DE_0100);

    // ---- Jump and branch together; response in the redirect cycle ----
    jump_decode  = 1'b1;
    pcsrc_decode = 1'b1;
    pc_jump      = 32'h200;
    pc_branch    = 32'h300;
    #1;
    check("jb_req_blocked", imem_req_valid, 0);
    tick();
    jump_decode  = 1'b0;
    pcsrc_decode = 1'b0;
    #1;
    check("jb_flushed",   instr_valid,    0);
    check("jb_req_valid", imem_req_valid, 1);
    check("jb_req_addr",  imem_req_addr,  32'h200);
    tick();
    check("jb_stale_dropped", instr_valid, 0);
    tick();
    check("jb_first_valid", instr_valid, 1);
    check("jb_first_pc",    pc_fetch,    32'h204);
    check("jb_first_instr", instr_fetch, 32'hC0DE_0200);

    // ---- Reset mid-stream with three requests in flight ----
    decode_ready = 1'b0;
    mem_auto     = 1'b0;
    mem_drive();
    #1;
    tick();
    tick();
    check("mid_credit_full",  imem_req_valid, 0);
    check("mid_instr_valid",  instr_valid,    1);
    check("mid_pc_fetch",     pc_fetch,       32'h204);
    check("mid_inflight",     32'(pend.size()), 3);
    rst      = 1'b1;
    mem_auto = 1'b1;
    mem_drive();
    #1;
    check("mrst_instr_valid", instr_valid,    0);
    check("mrst_instr_fetch", instr_fetch,    0);
    check("mrst_pc_fetch",    pc_fetch,       0);
    check("mrst_req_valid",   imem_req_valid, 0);
    tick();
    tick();
    rst          = 1'b0;
    decode_ready = 1'b1;
    #1;
    check("post_req_valid",   imem_req_valid, 1);
    check("post_req_addr",    imem_req_addr,  32'h0);
    check("post_instr_valid", instr_valid,    0);
    tick();
    check("post_stale_ignored", instr_valid, 0);
    tick();
    check("post_first_valid", instr_valid, 1);
    check("post_first_pc",    pc_fetch,    32'h4);
    check("post_first_instr", instr_fetch, 32'hC0DE_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
